seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed hex display driver for common-anode 7-segment banks. It captures a packed multi-digit hex word and refreshes one digit per prescaler tick, driving shared segment lines and one-hot anode enables. It sits between the datapath that produces display values and the board pins. It replaces per-digit combinational decoders with one shared decoder. Display updates are tear-free: new data is applied only at frame boundaries.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; must be ≥2.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥2.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg_out` at the pin (lit segment = 0).
- `clk`  input  1: system clock; all state is on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `load`  input  1: single-cycle strobe that captures `data_in`.
- `data_in`  input  4*NUM_DIGITS: packed nibbles; digit 0 is bits [3:0] and is the rightmost digit.
- `blank_mask`  input  NUM_DIGITS: 1 blanks that digit (its anode stays off); sampled live.
- `seg_out`  output  7: {g,f,e,d,c,b,a}, with polarity set by `SEG_ACTIVE_LOW`.
- `an_out`  output  NUM_DIGITS: one-hot anode enables, active-low.
- `frame_start`  output  1: one-cycle pulse when digit 0 becomes active.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
  - `tick` is asserted in the cycle the count equals REFRESH_DIV-1.
- Digit index (width clog2(NUM_DIGITS)) advances on `tick`.
  - It wraps from NUM_DIGITS-1 to 0; that wrap is the frame boundary.
- Shadow register:
  - `load`=1 writes `data_in` into shadow and sets `pending`.
  - A later `load` before the swap overwrites shadow; last write wins.
- Display register:
  - On the frame-boundary `tick` with `pending`=1, display ← shadow and `pending` clears.
  - If `load` coincides with the swap, the swap copies the old shadow. Shadow takes the new value and `pending` stays set, so the new value applies next frame.
- Decode uses the standard hex glyphs, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blanked digit: segments all off and all anodes off for that slot.

## Timing
- Reset values:
  - prescaler=0, digit index=NUM_DIGITS-1, shadow=0, display=0, `pending`=0.
  - `an_out`=all 1s, `seg_out`=all off (7'h7F when active-low), `frame_start`=0.
- The first `tick` after reset wraps the index to 0, which is a frame boundary. `an_out`/`seg_out` show digit 0 from the next cycle.
- Outputs are registered, so there is a 1-cycle latency from `tick` to new `an_out`/`seg_out`. `frame_start` is registered in the same cycle as the digit-0 outputs.
- `an_out` and `seg_out` change together on the same edge; no cycle has a new anode with stale segments.
- `load`-to-visible latency: at most NUM_DIGITS*REFRESH_DIV+1 cycles; at least 2 cycles when `load` directly precedes the boundary tick.
- `blank_mask` takes effect at the next slot update, not mid-slot.
- `rst_n` asserted mid-frame forces reset values immediately, without waiting for a clock. Captured but unswapped data is lost.

## Configuration
- Macro: `SEG7_LZ_SUPPRESS_EN`.
- Defined: leading-zero suppression.
  - Digits above the highest nonzero digit of the display register are blanked as if their `blank_mask` bit were set.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Suppression ORs with `blank_mask`.
- Undefined: all digits show per `blank_mask` only; no suppression logic is present.

## Structure
- Package `seg7_pkg`: the 16-entry glyph constants, the {g..a} bit-position constants, and the `seg7_glyph_t` 7-bit typedef.
- Sub-module `seg7_hex_decode`: combinational nibble→glyph lookup, active-high; a single instance. Polarity inversion stays in the top.

## Test plan
Benches use NUM_DIGITS=4, REFRESH_DIV=4.
- Reset release, no load: after the first tick, `an_out`=1110 and `seg_out`=~3F. `frame_start` pulses once every 16 cycles.
- `load` 16'h1A3F: after the next boundary, slots 0..3 show ~71, ~4F, ~77, ~06 with `an_out`=1110, 1101, 1011, 0111.
- `load` 16'h1234 coincident with the boundary tick (previous shadow 16'hBEEF pending): that frame shows BEEF and the next frame shows 1234.
- `blank_mask`=4'b0101 with data 16'h8888: slots 0 and 2 have `an_out`=1111 and segments off; slots 1 and 3 show ~7F.
- `rst_n` low mid-slot 2: outputs go to all-off immediately, with no clock edge. After release, scanning restarts at digit 0 showing 0.
- With `SEG7_LZ_SUPPRESS_EN`, data 16'h0040: digits 3 and 2 are blank, digit 1 shows ~66, digit 0 shows ~3F. Data 16'h0000 shows only digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph definitions for the 7-segment scan driver.
// Glyphs are active-high, packed {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_glyph_t;

    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    localparam seg7_glyph_t GLYPH_0 = 7'h3F;
    localparam seg7_glyph_t GLYPH_1 = 7'h06;
    localparam seg7_glyph_t GLYPH_2 = 7'h5B;
    localparam seg7_glyph_t GLYPH_3 = 7'h4F;
    localparam seg7_glyph_t GLYPH_4 = 7'h66;
    localparam seg7_glyph_t GLYPH_5 = 7'h6D;
    localparam seg7_glyph_t GLYPH_6 = 7'h7D;
    localparam seg7_glyph_t GLYPH_7 = 7'h07;
    localparam seg7_glyph_t GLYPH_8 = 7'h7F;
    localparam seg7_glyph_t GLYPH_9 = 7'h6F;
    localparam seg7_glyph_t GLYPH_A = 7'h77;
    localparam seg7_glyph_t GLYPH_B = 7'h7C;
    localparam seg7_glyph_t GLYPH_C = 7'h39;
    localparam seg7_glyph_t GLYPH_D = 7'h5E;
    localparam seg7_glyph_t GLYPH_E = 7'h79;
    localparam seg7_glyph_t GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]  nibble,
    output seg7_glyph_t glyph
);

    always_comb begin
        glyph = GLYPH_0;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver with frame-synchronous (tear-free) updates.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    function automatic logic [6:0] to_pin(input seg7_glyph_t g);
        return (SEG_ACTIVE_LOW != 0) ? ~g : g;
    endfunction

    logic [CNT_W-1:0]        cnt_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic [IDX_W-1:0]        idx_nxt;
    logic [4*NUM_DIGITS-1:0] shadow_p0;
    logic [4*NUM_DIGITS-1:0] display_p0;
    logic [4*NUM_DIGITS-1:0] display_nxt;
    logic                    pending_p0;
    logic                    tick;
    logic                    boundary;
    logic [3:0]              nibble;
    seg7_glyph_t             glyph;
    logic                    blank_nxt;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [6:0]              seg_p1;
    logic [NUM_DIGITS-1:0]   an_p1;
    logic                    frame_p1;

    assign tick        = (cnt_p0 == LAST_CNT);
    assign boundary    = tick && (idx_p0 == LAST_IDX);
    assign idx_nxt     = (idx_p0 == LAST_IDX) ? '0 : idx_p0 + IDX_W'(1);
    // Slot outputs are built from the post-swap value so digit 0 of a new frame is already fresh.
    assign display_nxt = (boundary && pending_p0) ? shadow_p0 : display_p0;

`ifdef SEG7_LZ_SUPPRESS_EN
    logic upper_zero;

    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (display_nxt[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        nibble    = 4'h0;
        blank_nxt = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nibble    = display_nxt[4*i +: 4];
                blank_nxt = blank_mask[i] | lz_mask[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

    // Stage p0: prescaler, digit index, shadow/display capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0     <= '0;
            idx_p0     <= LAST_IDX;
            shadow_p0  <= '0;
            display_p0 <= '0;
            pending_p0 <= 1'b0;
        end else begin
            cnt_p0     <= tick ? '0 : cnt_p0 + CNT_W'(1);
            display_p0 <= display_nxt;
            if (tick) begin
                idx_p0 <= idx_nxt;
            end
            if (load) begin
                shadow_p0  <= data_in;
                pending_p0 <= 1'b1;
            end else if (boundary) begin
                pending_p0 <= 1'b0;
            end
        end
    end

    // Stage p1: registered pin drivers, anode and segments updated together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1   <= SEG_OFF;
            an_p1    <= '1;
            frame_p1 <= 1'b0;
        end else begin
            frame_p1 <= boundary;
            if (tick) begin
                an_p1  <= blank_nxt ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
                seg_p1 <= blank_nxt ? SEG_OFF : to_pin(glyph);
            end
        end
    end

    assign seg_out     = seg_p1;
    assign an_out      = an_p1;
    assign frame_start = frame_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 cycles per slot).
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_mask;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_start;

    int n_checks = 0;
    int n_err    = 0;

    seg7_scan_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .data_in     (data_in),
        .blank_mask  (blank_mask),
        .seg_out     (seg_out),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: slot position derived from elapsed cycles since reset release.
    int          m_cyc;
    logic [15:0] m_shadow;
    logic [15:0] m_display;
    bit          m_pending;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_fs;

    task automatic model_reset();
        m_cyc     = 0;
        m_shadow  = 16'h0;
        m_display = 16'h0;
        m_pending = 0;
        m_an      = 4'hF;
        m_seg     = 7'h7F;
        m_fs      = 1'b0;
    endtask

    task automatic model_edge();
        bit         tick;
        bit         boundary;
        bit         blank;
        int         d;
        logic [3:0] nib;
        tick     = (m_cyc % R) == (R - 1);
        d        = (m_cyc / R) % N;
        boundary = tick && (d == 0);
        if (boundary && m_pending) begin
            m_display = m_shadow;
            m_pending = 0;
        end
        if (load) begin
            m_shadow  = data_in;
            m_pending = 1;
        end
        m_fs = boundary;
        if (tick) begin
            nib   = m_display[4*d +: 4];
            blank = blank_mask[d];
`ifdef SEG7_LZ_SUPPRESS_EN
            if (d > 0 && (m_display >> (4*d)) == 16'h0) blank = 1;
`endif
            m_an  = blank ? 4'hF : ~(4'b0001 << d);
            m_seg = blank ? 7'h7F : ~GLYPHS[nib];
        end
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_an",  16'(an_out),      16'(m_an));
        chk("model_seg", 16'(seg_out),     16'(m_seg));
        chk("model_fs",  16'(frame_start), 16'(m_fs));
    endtask

    task automatic wait_fs();
        for (int k = 0; k < 40; k++) begin
            step();
            if (frame_start) break;
        end
        chk("wait_frame_start", 16'(frame_start), 16'h1);
    endtask

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0][6:0] seg;
        logic [3:0][3:0] an;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int fs_cnt;
        int fs_first;
        logic [6:0] coinc_seg [8];

        vecs[0] = '{data: 16'h1A3F, blank: 4'b0000,
                    seg: {7'h79, 7'h08, 7'h30, 7'h0E}, an: {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[1] = '{data: 16'h8888, blank: 4'b0101,
                    seg: {7'h00, 7'h7F, 7'h00, 7'h7F}, an: {4'h7, 4'hF, 4'hD, 4'hF}};
`ifdef SEG7_LZ_SUPPRESS_EN
        vecs[2] = '{data: 16'h0040, blank: 4'b0000,
                    seg: {7'h7F, 7'h7F, 7'h19, 7'h40}, an: {4'hF, 4'hF, 4'hD, 4'hE}};
        vecs[3] = '{data: 16'h0000, blank: 4'b0000,
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, an: {4'hF, 4'hF, 4'hF, 4'hE}};
`else
        vecs[2] = '{data: 16'h0040, blank: 4'b0000,
                    seg: {7'h40, 7'h40, 7'h19, 7'h40}, an: {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[3] = '{data: 16'h0000, blank: 4'b0000,
                    seg: {7'h40, 7'h40, 7'h40, 7'h40}, an: {4'h7, 4'hB, 4'hD, 4'hE}};
`endif
        // BEEF frame then 1234 frame, slot 0 first
        coinc_seg = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h19, 7'h30, 7'h24, 7'h79};

        rst_n      = 1'b1;
        load       = 1'b0;
        data_in    = 16'h0;
        blank_mask = 4'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_an",  16'(an_out),      16'hF);
        chk("reset_seg", 16'(seg_out),     16'h7F);
        chk("reset_fs",  16'(frame_start), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();

        // First tick after reset shows digit 0 of zero
        repeat (R) step();
        chk("first_tick_an",  16'(an_out),      16'hE);
        chk("first_tick_seg", 16'(seg_out),     16'h40);
        chk("first_tick_fs",  16'(frame_start), 16'h1);
        fs_cnt   = 0;
        fs_first = -1;
        for (int i = 0; i < 2 * N * R; i++) begin
            step();
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
            end
        end
        chk("fs_count",  16'(fs_cnt),   16'd2);
        chk("fs_period", 16'(fs_first), 16'(N * R - 1));

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            blank_mask = vecs[v].blank;
            data_in    = vecs[v].data;
            load       = 1'b1;
            step();
            load = 1'b0;
            wait_fs();
            wait_fs();
            for (int s = 0; s < N; s++) begin
                chk($sformatf("vec%0d_slot%0d_seg", v, s), 16'(seg_out), 16'(vecs[v].seg[s]));
                chk($sformatf("vec%0d_slot%0d_an",  v, s), 16'(an_out),  16'(vecs[v].an[s]));
                if (s < N - 1) repeat (R) step();
            end
        end

        // Load coincident with the boundary tick while BEEF is pending
        blank_mask = 4'h0;
        wait_fs();
        for (int n = 1; n <= N * R; n++) begin
            load    = (n == 6) || (n == N * R);
            data_in = (n == 6) ? 16'hBEEF : 16'h1234;
            step();
        end
        load = 1'b0;
        for (int s = 0; s < 2 * N; s++) begin
            chk($sformatf("coinc_slot%0d_seg", s), 16'(seg_out), 16'(coinc_seg[s]));
            repeat (R) step();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom % 8) == 0;
            data_in = 16'($urandom);
            if (($urandom % 32) == 0) blank_mask = 4'($urandom);
            step();
        end
        load       = 1'b0;
        blank_mask = 4'h0;

        // Asynchronous reset mid-slot 2 with unswapped data captured
        wait_fs();
        data_in = 16'h5555;
        load    = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * R) step();
        chk("pre_reset_an", 16'(an_out), 16'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_an",  16'(an_out),      16'hF);
        chk("async_reset_seg", 16'(seg_out),     16'h7F);
        chk("async_reset_fs",  16'(frame_start), 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        repeat (R) step();
        chk("restart_an",  16'(an_out),  16'hE);
        chk("restart_seg", 16'(seg_out), 16'h40);
        repeat (N * R) step();
        chk("lost_shadow_seg", 16'(seg_out), 16'h40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
